ipml_fifo_mc_sync_v1_0: RTL

Single-clock, multi-channel synchronous FIFO. c_CH_NUM logical FIFOs share one storage array, partitioned into equal regions of 2^c_DEPTH_WIDTH words each. There is one write port and one read port, each with a channel select. Every channel has its own pointers, water level, full/empty and almost flags, and the block keeps sticky overflow/underflow error bits. It sits between per-channel producers (e.g. audio frame splitters) and a shared consumer, and replaces multiple single-channel sync FIFO instances.

---
 rtl/ipml_fifo_mc_pkg.sv | 30 +++
 rtl/ipml_fifo_mc_ch_ctrl.sv | 99 +++++++++
 rtl/ipml_fifo_mc_sync_v1_0.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ipml_fifo_mc_pkg.sv
// ipml_fifo_mc_pkg
// Shared definitions for the multi-channel sync FIFO:
//   c_CH_DEPTH      - per-channel depth for the default depth width
//   ch_depth()      - words per channel for a given depth width
//   level_lsb()     - LSB of a channel's slice in the packed water_level bus
//   params_legal()  - elaboration-time legality check of the top parameters
package ipml_fifo_mc_pkg;

    localparam int unsigned c_DEF_DEPTH_WIDTH = 9;
    localparam int unsigned c_CH_DEPTH        = 2 ** c_DEF_DEPTH_WIDTH;

    function automatic int unsigned ch_depth(input int unsigned depth_width);
        return 32'd1 << depth_width;
    endfunction

    function automatic int unsigned level_lsb(input int unsigned ch, input int unsigned depth_width);
        return ch * (depth_width + 1);
    endfunction

    function automatic bit params_legal(input int unsigned ch_num,
                                        input int unsigned sel_width,
                                        input int unsigned depth_width,
                                        input int unsigned almost_full_num);
        return (sel_width == $clog2(ch_num)) &&
               (almost_full_num <= ch_depth(depth_width)) &&
               (ch_num >= 2) && (ch_num <= 16) &&
               (depth_width >= 4) && (depth_width <= 12);
    endfunction

endpackage

// File: rtl/ipml_fifo_mc_ch_ctrl.sv
// ipml_fifo_mc_ch_ctrl
// Per-channel pointer, level, flag and sticky-error logic.
// Ports:
//   clk, rst         - clock, async active-high reset
//   wr_req, rd_req   - access requests already qualified by channel select
//   err_clr          - clears sticky error bits (a same-cycle new error wins)
//   wr_acc, rd_acc   - accepted accesses (judged on registered flags)
//   wptr, rptr       - word pointers inside this channel's region
//   level            - word count, 0..2^D
//   full, empty, almost_full, almost_empty, overflow, underflow - status
module ipml_fifo_mc_ch_ctrl
    import ipml_fifo_mc_pkg::*;
#(
    parameter int c_DEPTH_WIDTH      = 9,
    parameter int c_ALMOST_FULL_NUM  = 508,
    parameter int c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_req,
    input  logic                     rd_req,
    input  logic                     err_clr,
    output logic                     wr_acc,
    output logic                     rd_acc,
    output logic [c_DEPTH_WIDTH-1:0] wptr,
    output logic [c_DEPTH_WIDTH-1:0] rptr,
    output logic [c_DEPTH_WIDTH:0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int c_LW = c_DEPTH_WIDTH + 1;
    localparam logic [c_DEPTH_WIDTH:0] c_FULL_LVL = c_LW'(ch_depth(c_DEPTH_WIDTH));
    localparam logic [c_DEPTH_WIDTH:0] c_AF_LVL   = c_LW'(c_ALMOST_FULL_NUM);
    localparam logic [c_DEPTH_WIDTH:0] c_AE_LVL   = c_LW'(c_ALMOST_EMPTY_NUM);

    logic [c_DEPTH_WIDTH-1:0] wptr_d, wptr_q, rptr_d, rptr_q;
    logic [c_DEPTH_WIDTH:0]   level_d, level_q;
    logic full_d, full_q, empty_d, empty_q, af_d, af_q, ae_d, ae_q;
    logic ovf_d, ovf_q, udf_d, udf_q;

    always_comb begin
        wr_acc  = wr_req && !full_q;
        rd_acc  = rd_req && !empty_q;
        wptr_d  = wr_acc ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = rd_acc ? rptr_q + 1'b1 : rptr_q;
        level_d = level_q;
        if (wr_acc && !rd_acc)
            level_d = level_q + 1'b1;
        else if (rd_acc && !wr_acc)
            level_d = level_q - 1'b1;
        full_d  = (level_d == c_FULL_LVL);
        empty_d = (level_d == '0);
        af_d    = (level_d >= c_AF_LVL);
        ae_d    = (level_d <= c_AE_LVL);
        // clear first, then OR in this cycle's error so a new error survives err_clr
        ovf_d   = (err_clr ? 1'b0 : ovf_q) | (wr_req && full_q);
        udf_d   = (err_clr ? 1'b0 : udf_q) | (rd_req && empty_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign wptr         = wptr_q;
    assign rptr         = rptr_q;
    assign level        = level_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: rtl/ipml_fifo_mc_sync_v1_0.sv
// ipml_fifo_mc_sync_v1_0
// Single-clock multi-channel FIFO: c_CH_NUM logical FIFOs share one
// simple dual-port array, channel k owning addresses {k, ptr}.
// Ports:
//   clk, rst                      - clock, async active-high reset
//   wr_en, wr_ch, wr_data         - write port with channel select
//   rd_en, rd_ch                  - read port with channel select
//   rd_data, rd_valid, rd_data_ch - read result (latency 1, or 2 with c_OUTPUT_REG)
//   wr_full, almost_full, rd_empty, almost_empty - per-channel flags
//   water_level                   - per-channel levels, ch k at [k*(D+1) +: D+1]
//   err_clr, overflow, underflow  - sticky per-channel error bits and clear
module ipml_fifo_mc_sync_v1_0
    import ipml_fifo_mc_pkg::*;
#(
    parameter int c_CH_NUM           = 4,
    parameter int c_CH_SEL_WIDTH     = 2,
    parameter int c_DEPTH_WIDTH      = 9,
    parameter int c_DATA_WIDTH       = 32,
    parameter int c_ALMOST_FULL_NUM  = 508,
    parameter int c_ALMOST_EMPTY_NUM = 4,
    parameter int c_OUTPUT_REG       = 0
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    wr_en,
    input  logic [c_CH_SEL_WIDTH-1:0]               wr_ch,
    input  logic [c_DATA_WIDTH-1:0]                 wr_data,
    input  logic                                    rd_en,
    input  logic [c_CH_SEL_WIDTH-1:0]               rd_ch,
    output logic [c_DATA_WIDTH-1:0]                 rd_data,
    output logic                                    rd_valid,
    output logic [c_CH_SEL_WIDTH-1:0]               rd_data_ch,
    output logic [c_CH_NUM-1:0]                     wr_full,
    output logic [c_CH_NUM-1:0]                     almost_full,
    output logic [c_CH_NUM-1:0]                     rd_empty,
    output logic [c_CH_NUM-1:0]                     almost_empty,
    output logic [c_CH_NUM*(c_DEPTH_WIDTH+1)-1:0]   water_level,
    input  logic                                    err_clr,
    output logic [c_CH_NUM-1:0]                     overflow,
    output logic [c_CH_NUM-1:0]                     underflow
);

    localparam int c_LW    = c_DEPTH_WIDTH + 1;
    localparam int c_AW    = c_CH_SEL_WIDTH + c_DEPTH_WIDTH;
    localparam int c_SLOTS = 1 << c_CH_SEL_WIDTH;

    if (!params_legal(c_CH_NUM, c_CH_SEL_WIDTH, c_DEPTH_WIDTH, c_ALMOST_FULL_NUM)) begin : g_param_err
        $error("ipml_fifo_mc_sync_v1_0: illegal parameter combination");
    end

    // indexed by the raw select so out-of-range selects read zero pointers;
    // their requests never match a channel, so nothing is accepted for them
    logic [c_DEPTH_WIDTH-1:0] wptr_arr [c_SLOTS];
    logic [c_DEPTH_WIDTH-1:0] rptr_arr [c_SLOTS];
    logic [c_CH_NUM-1:0]      wr_acc_vec, rd_acc_vec;

    for (genvar k = 0; k < c_SLOTS; k++) begin : g_ch
        if (k < c_CH_NUM) begin : g_used
            logic [c_DEPTH_WIDTH:0] level_k;
            ipml_fifo_mc_ch_ctrl #(
                .c_DEPTH_WIDTH     (c_DEPTH_WIDTH),
                .c_ALMOST_FULL_NUM (c_ALMOST_FULL_NUM),
                .c_ALMOST_EMPTY_NUM(c_ALMOST_EMPTY_NUM)
            ) u_ch_ctrl (
                .clk         (clk),
                .rst         (rst),
                .wr_req      (wr_en && (wr_ch == c_CH_SEL_WIDTH'(k))),
                .rd_req      (rd_en && (rd_ch == c_CH_SEL_WIDTH'(k))),
                .err_clr     (err_clr),
                .wr_acc      (wr_acc_vec[k]),
                .rd_acc      (rd_acc_vec[k]),
                .wptr        (wptr_arr[k]),
                .rptr        (rptr_arr[k]),
                .level       (level_k),
                .full        (wr_full[k]),
                .empty       (rd_empty[k]),
                .almost_full (almost_full[k]),
                .almost_empty(almost_empty[k]),
                .overflow    (overflow[k]),
                .underflow   (underflow[k])
            );
            assign water_level[level_lsb(k, c_DEPTH_WIDTH) +: c_LW] = level_k;
        end else begin : g_unused
            assign wptr_arr[k] = '0;
            assign rptr_arr[k] = '0;
        end
    end

    logic                    wr_acc_any, rd_acc_any;
    logic [c_AW-1:0]         waddr, raddr;
    logic [c_DATA_WIDTH-1:0] mem [1 << c_AW];

    assign wr_acc_any = |wr_acc_vec;
    assign rd_acc_any = |rd_acc_vec;
    assign waddr      = {wr_ch, wptr_arr[wr_ch]};
    assign raddr      = {rd_ch, rptr_arr[rd_ch]};

    // storage is deliberately unreset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_acc_any)
            mem[waddr] <= wr_data;
    end

    logic                      rd_valid_s1_d, rd_valid_s1_q;
    logic [c_CH_SEL_WIDTH-1:0] rd_ch_s1_d, rd_ch_s1_q;
    logic [c_DATA_WIDTH-1:0]   rd_data_s1_q;

    always_comb begin
        rd_valid_s1_d = rd_acc_any;
        rd_ch_s1_d    = rd_acc_any ? rd_ch : rd_ch_s1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_s1_q <= 1'b0;
            rd_ch_s1_q    <= '0;
            rd_data_s1_q  <= '0;
        end else begin
            rd_valid_s1_q <= rd_valid_s1_d;
            rd_ch_s1_q    <= rd_ch_s1_d;
            if (rd_acc_any)
                rd_data_s1_q <= mem[raddr];
        end
    end

    if (c_OUTPUT_REG != 0) begin : g_oreg
        logic                      rd_valid_s2_q;
        logic [c_CH_SEL_WIDTH-1:0] rd_ch_s2_d, rd_ch_s2_q;
        logic [c_DATA_WIDTH-1:0]   rd_data_s2_d, rd_data_s2_q;

        always_comb begin
            rd_ch_s2_d   = rd_valid_s1_q ? rd_ch_s1_q : rd_ch_s2_q;
            rd_data_s2_d = rd_valid_s1_q ? rd_data_s1_q : rd_data_s2_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_valid_s2_q <= 1'b0;
                rd_ch_s2_q    <= '0;
                rd_data_s2_q  <= '0;
            end else begin
                rd_valid_s2_q <= rd_valid_s1_q;
                rd_ch_s2_q    <= rd_ch_s2_d;
                rd_data_s2_q  <= rd_data_s2_d;
            end
        end

        assign rd_valid   = rd_valid_s2_q;
        assign rd_data_ch = rd_ch_s2_q;
        assign rd_data    = rd_data_s2_q;
    end else begin : g_noreg
        assign rd_valid   = rd_valid_s1_q;
        assign rd_data_ch = rd_ch_s1_q;
        assign rd_data    = rd_data_s1_q;
    end

endmodule
